// File: rtl/float_pkg.sv
// Shared single-precision float definitions plus helpers reused by the float
// pipeline stages (state type for the integer converter, RNE rounding).
package float_pkg;

    localparam int MantissaWidth       = 23;
    localparam int BiasedExponentWidth = 8;
    localparam int Bias                = 127;

    typedef struct packed {
        logic                           sign;
        logic [BiasedExponentWidth-1:0] exponent;
        logic [MantissaWidth-1:0]       mantissa;
    } float_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } int_to_float_state_e;

    // Round-to-nearest-even on a truncated mantissa. Returns {carry, mant}; on
    // carry the mantissa field wraps to zero and the caller bumps the exponent.
    function automatic logic [MantissaWidth:0] float_round_rne(
        input logic [MantissaWidth-1:0] mant,
        input logic                     guard,
        input logic                     sticky
    );
        logic w_up;
        w_up = guard & (sticky | mant[0]);
        return {1'b0, mant} + {{MantissaWidth{1'b0}}, w_up};
    endfunction

endpackage

// File: rtl/int_to_float.sv
// Multi-cycle integer to float converter: captures a signed/unsigned word,
// normalises it one bit per clock, rounds RNE and holds the result until taken.
module int_to_float
    import float_pkg::*;
#(
    parameter int IntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IntWidth-1:0] in_data_i,
    input  logic                in_signed_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output float_t              out_data_o,
    output logic                inexact_o
);

    localparam int FracW = IntWidth - 1;
    localparam int ExtW  = FracW + MantissaWidth + 1;
    localparam logic [BiasedExponentWidth-1:0] ExpInit =
        BiasedExponentWidth'(Bias + IntWidth - 1);

    if (Bias + IntWidth - 1 >= 2**BiasedExponentWidth - 1) begin : gen_exp_range_check
        $error("int_to_float: IntWidth too large, conversion could overflow to infinity");
    end

    int_to_float_state_e r_state;
    int_to_float_state_e w_next_state;

    logic                           r_sign;
    logic [IntWidth-1:0]            r_mag;
    logic [BiasedExponentWidth-1:0] r_exp;
    float_t                         r_out;
    logic                           r_inexact;

    logic                     w_accept;
    logic                     w_in_sign;
    logic [IntWidth-1:0]      w_in_mag;
    logic                     w_norm_done;
    logic [ExtW-1:0]          w_ext;
    logic [MantissaWidth-1:0] w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic [MantissaWidth:0]   w_round;

    assign w_accept  = in_valid_i & (r_state == IDLE);
    assign w_in_sign = in_signed_i & in_data_i[IntWidth-1];
    // Unsigned negate: the signed minimum maps to 2**(IntWidth-1) exactly.
    assign w_in_mag  = w_in_sign ? (IntWidth'(0) - in_data_i) : in_data_i;

    assign w_norm_done = (r_state == NORM) & r_mag[IntWidth-1];

    // Zero-padding on the right covers words narrower than the mantissa.
    assign w_ext    = {r_mag[FracW-1:0], {(MantissaWidth + 1){1'b0}}};
    assign w_mant   = w_ext[ExtW-1 -: MantissaWidth];
    assign w_guard  = w_ext[ExtW-1-MantissaWidth];
    assign w_sticky = |w_ext[ExtW-2-MantissaWidth:0];
    assign w_round  = float_round_rne(w_mant, w_guard, w_sticky);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid_i) begin
                    w_next_state = (w_in_mag == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (r_mag[IntWidth-1]) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Working operand: only meaningful while NORM, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_sign <= w_in_sign;
            r_mag  <= w_in_mag;
            r_exp  <= ExpInit;
        end else if ((r_state == NORM) && !r_mag[IntWidth-1]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out     <= '0;
            r_inexact <= 1'b0;
        end else if (w_accept && (w_in_mag == '0)) begin
            r_out     <= '0;
            r_inexact <= 1'b0;
        end else if (w_norm_done) begin
            r_out.sign     <= r_sign;
            r_out.exponent <= r_exp + {{(BiasedExponentWidth-1){1'b0}}, w_round[MantissaWidth]};
            r_out.mantissa <= w_round[MantissaWidth-1:0];
            r_inexact      <= w_guard | w_sticky;
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign out_data_o  = r_out;
    assign inexact_o   = r_inexact;

endmodule

// File: tb/tb_int_to_float.sv
// Testbench for int_to_float: directed vector table, handshake corner cases and
// randomised words checked against an arithmetic RNE reference model.
module tb_int_to_float;
    import float_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    float_t      out_data;
    logic        inexact;

    int total  = 0;
    int passed = 0;

    int_to_float #(.IntWidth(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_signed_i (in_signed),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .inexact_o   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [31:0] bits;
        logic        inex;
        int          edges;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: exact value m = q*2^shift + rem, rounded by comparing rem to half an ulp.
    task automatic model(input logic [31:0] d, input logic s,
                         output logic [31:0] bits, output logic inex, output int edges);
        logic           sign;
        longint unsigned m, q, rem, half;
        int             p, shift;
        sign = s & d[31];
        m = sign ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
        if (m == 0) begin
            bits = 32'd0; inex = 1'b0; edges = 0;
            return;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        edges = 32 - p;
        if (p <= 23) begin
            q = m << (23 - p);
            rem = 0;
        end else begin
            shift = p - 23;
            q = m >> shift;
            rem = m - (q << shift);
            half = 64'd1 << (shift - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        inex = (rem != 0);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        bits = {sign, 8'(127 + p), q[22:0]};
    endtask

    task automatic convert(input logic [31:0] d, input logic s,
                           output logic [31:0] bits, output logic inex, output int edges);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        edges    = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) edges = -1;
        bits = out_data;
        inex = inexact;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [31:0] d, input logic s,
                                 input logic [31:0] eb, input logic ei, input int ee);
        logic [31:0] ab;
        logic        ai;
        int          ae;
        convert(d, s, ab, ai, ae);
        check({name, "_data"}, ab, eb);
        check({name, "_inexact"}, {31'd0, ai}, {31'd0, ei});
        check({name, "_latency"}, ae, ee);
        consume();
    endtask

    vec_t        vecs[8];
    logic [31:0] mb;
    logic        mi;
    int          me;
    logic [31:0] held;
    logic        seen_valid;

    initial begin
        vecs[0] = '{32'd1,        1'b0, 32'h3F800000, 1'b0, 32};
        vecs[1] = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 32};
        vecs[2] = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0, 1};
        vecs[3] = '{32'd0,        1'b0, 32'h00000000, 1'b0, 0};
        vecs[4] = '{32'd0,        1'b1, 32'h00000000, 1'b0, 0};
        vecs[5] = '{32'd16777217, 1'b0, 32'h4B800000, 1'b1, 8};
        vecs[6] = '{32'd16777219, 1'b0, 32'h4B800002, 1'b1, 8};
        vecs[7] = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 1};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_signed = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_inexact",   {31'd0, inexact},   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].sgn,
                          vecs[i].bits, vecs[i].inex, vecs[i].edges);
        end

        // Backpressure: result held, input ignored while pending.
        model(32'd5, 1'b0, mb, mi, me);
        run_and_check_hold: begin
            logic [31:0] ab;
            logic        ai;
            int          ae;
            convert(32'd5, 1'b0, ab, ai, ae);
            check("bp_data", ab, mb);
            held = ab;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                in_valid = (i == 2);
                in_data  = 32'h12345678;
                @(posedge clk);
                #1;
                check("bp_hold_data",  out_data,           held);
                check("bp_in_ready",   {31'd0, in_ready},  32'd0);
                check("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            end
            in_valid = 1'b0;
            consume();
            check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
            check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        end
        model(32'd7, 1'b0, mb, mi, me);
        run_and_check("after_bp", 32'd7, 1'b0, mb, mi, me);

        // Reset in the middle of normalisation.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd1; in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data",  out_data,           32'd0);
        check("midrst_inexact",   {31'd0, inexact},   32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", {31'd0, seen_valid}, 32'd0);
        run_and_check("after_rst", 32'd3, 1'b0, 32'h40400000, 1'b0, 31);

        // Randomised words across the whole dynamic range.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] d;
            logic        s;
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = ~d;
            s = $urandom_range(0, 1);
            model(d, s, mb, mi, me);
            run_and_check($sformatf("rnd%0d", i), d, s, mb, mi, me);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
